// File: rtl/prco_alu_stage.sv
// prco_alu_stage: execute stage of the PRCO 16-bit pipelined CPU.
// Computes a registered result from opcode and operands and holds the Z/N/V compare flags.
// Raises a branch request for taken jumps.
// Hands off with a one-cycle strobe to the RAM stage or the write-back stage.
// Optional feature macro: PRCO_ALU_SHIFT_EN enables LSL/LSR (0A/0B); without it they
// behave as undefined opcodes.
module prco_alu_stage (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic        i_dec_req_ram,
   input  logic [5:0]  i_op,
   input  logic [15:0] i_data,
   input  logic [15:0] i_datb,
   input  logic [15:0] i_imm8,
   input  logic [4:0]  i_simm5,
   output logic [15:0] q_result,
   output logic        q_ce_ram,
   output logic        q_ce_reg,
   output logic        q_should_branch
);

   localparam logic [5:0] OpAdd  = 6'h01;
   localparam logic [5:0] OpSub  = 6'h02;
   localparam logic [5:0] OpAddi = 6'h03;
   localparam logic [5:0] OpSubi = 6'h04;
   localparam logic [5:0] OpMovi = 6'h05;
   localparam logic [5:0] OpMov  = 6'h06;
   localparam logic [5:0] OpAnd  = 6'h07;
   localparam logic [5:0] OpOr   = 6'h08;
   localparam logic [5:0] OpXor  = 6'h09;
`ifdef PRCO_ALU_SHIFT_EN
   localparam logic [5:0] OpLsl  = 6'h0A;
   localparam logic [5:0] OpLsr  = 6'h0B;
`endif
   localparam logic [5:0] OpCmp  = 6'h0C;
   localparam logic [5:0] OpJmp  = 6'h0D;
   localparam logic [5:0] OpJe   = 6'h0E;
   localparam logic [5:0] OpJne  = 6'h0F;
   localparam logic [5:0] OpJg   = 6'h10;
   localparam logic [5:0] OpJl   = 6'h11;
   localparam logic [5:0] OpLw   = 6'h12;
   localparam logic [5:0] OpSw   = 6'h13;
   localparam logic [5:0] OpUart = 6'h14;
   localparam logic [5:0] OpHalt = 6'h3F;

   logic [15:0] r_result;
   logic        r_ce_ram;
   logic        r_ce_reg;
   logic        r_branch;
   logic        r_z;
   logic        r_n;
   logic        r_v;

   logic [15:0] w_result;
   logic        w_take;
   logic [15:0] w_diff;
   logic [15:0] w_simm;
   logic        w_cmp_z;
   logic        w_cmp_n;
   logic        w_cmp_v;

   // Shared Rd-Ra difference feeds both SUB and the CMP flag update.
   assign w_diff  = i_datb - i_data;
   assign w_simm  = {{11{i_simm5[4]}}, i_simm5};
   assign w_cmp_z = (w_diff == 16'h0000);
   assign w_cmp_n = w_diff[15];
   assign w_cmp_v = (i_datb[15] != i_data[15]) && (w_diff[15] != i_datb[15]);

   // Result mux and branch-condition decode.
   always_comb begin
      w_result = 16'h0000;
      w_take   = 1'b0;
      case (i_op)
         OpAdd:  w_result = i_datb + i_data;
         OpSub:  w_result = w_diff;
         OpAddi: w_result = i_datb + i_imm8;
         OpSubi: w_result = i_datb - i_imm8;
         OpMovi: w_result = i_imm8;
         OpMov:  w_result = i_data;
         OpAnd:  w_result = i_datb & i_data;
         OpOr:   w_result = i_datb | i_data;
         OpXor:  w_result = i_datb ^ i_data;
`ifdef PRCO_ALU_SHIFT_EN
         OpLsl:  w_result = i_datb << i_data[3:0];
         OpLsr:  w_result = i_datb >> i_data[3:0];
`endif
         OpCmp:  w_result = i_datb;
         OpJmp: begin
            w_result = i_imm8;
            w_take   = 1'b1;
         end
         OpJe: begin
            w_result = i_imm8;
            w_take   = r_z;
         end
         OpJne: begin
            w_result = i_imm8;
            w_take   = !r_z;
         end
         OpJg: begin
            w_result = i_imm8;
            w_take   = !r_z && (r_n == r_v);
         end
         OpJl: begin
            w_result = i_imm8;
            w_take   = (r_n != r_v);
         end
         OpLw:   w_result = i_data + w_simm;
         OpSw:   w_result = i_data + w_simm;
         OpUart: w_result = i_datb;
         OpHalt: w_result = 16'h0000;
         default: w_result = 16'h0000;
      endcase
   end

   // Compare flags change only on an accepted CMP.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_z <= 1'b0;
         r_n <= 1'b0;
         r_v <= 1'b0;
      end else if (i_ce && (i_op == OpCmp)) begin
         r_z <= w_cmp_z;
         r_n <= w_cmp_n;
         r_v <= w_cmp_v;
      end
   end

   // Result register and one-cycle handoff strobes.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_result <= 16'h0000;
         r_ce_ram <= 1'b0;
         r_ce_reg <= 1'b0;
         r_branch <= 1'b0;
      end else begin
         r_ce_ram <= i_ce & i_dec_req_ram;
         r_ce_reg <= i_ce & ~i_dec_req_ram;
         r_branch <= i_ce & w_take;
         if (i_ce) begin
            r_result <= w_result;
         end
      end
   end

   assign q_result        = r_result;
   assign q_ce_ram        = r_ce_ram;
   assign q_ce_reg        = r_ce_reg;
   assign q_should_branch = r_branch;

endmodule

// File: tb/tb_prco_alu_stage.sv
// Directed self-checking bench for prco_alu_stage.
// Expected shift results follow PRCO_ALU_SHIFT_EN.
module tb_prco_alu_stage;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        req_ram;
   logic [5:0]  op;
   logic [15:0] data;
   logic [15:0] datb;
   logic [15:0] imm8;
   logic [4:0]  simm5;
   logic [15:0] result;
   logic        ce_ram;
   logic        ce_reg;
   logic        br;

   int n_assert = 0;
   int n_fail   = 0;

   prco_alu_stage dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_ce            (ce),
      .i_dec_req_ram   (req_ram),
      .i_op            (op),
      .i_data          (data),
      .i_datb          (datb),
      .i_imm8          (imm8),
      .i_simm5         (simm5),
      .q_result        (result),
      .q_ce_ram        (ce_ram),
      .q_ce_reg        (ce_reg),
      .q_should_branch (br)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check the three strobes together as {ram, reg, branch}.
   task automatic check_strb(input string tag, input logic [2:0] exp);
      check(tag, {13'd0, ce_ram, ce_reg, br}, {13'd0, exp});
   endtask

   task automatic drive(input logic [5:0] o, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] im, input logic [4:0] s, input logic ram);
      ce      = 1'b1;
      op      = o;
      data    = a;
      datb    = d;
      imm8    = im;
      simm5   = s;
      req_ram = ram;
   endtask

   // Single accepted instruction: drive at negedge, sample 1 ns after the edge.
   task automatic issue(input logic [5:0] o, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] im, input logic [4:0] s, input logic ram);
      @(negedge clk);
      drive(o, a, d, im, s, ram);
      @(posedge clk);
      #1;
      ce = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ce = 1'b0; req_ram = 1'b0; op = '0; data = '0; datb = '0; imm8 = '0; simm5 = '0;
      // i_ce held high during reset must be ignored.
      #2;
      drive(6'h05, 16'h0, 16'h0, 16'hAAAA, 5'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", result, 16'h0000);
      check_strb("reset_strobes", 3'b000);
      ce = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Idle: no strobes for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_strb("idle_strobes", 3'b000);
      end
      check("idle_result", result, 16'h0000);

      // ADD wraps modulo 2^16.
      issue(6'h01, 16'h0002, 16'hFFFF, 16'h0, 5'h0, 1'b0);
      check("add_result", result, 16'h0001);
      check_strb("add_strobes", 3'b010);
      @(posedge clk);
      #1;
      check_strb("add_strobe_drop", 3'b000);
      check("add_hold", result, 16'h0001);

      // LW: Ra + sext(-2), RAM handoff.
      issue(6'h12, 16'h0010, 16'h0, 16'h0, 5'h1E, 1'b1);
      check("lw_result", result, 16'h000E);
      check_strb("lw_strobes", 3'b100);

      // SW: positive offset.
      issue(6'h13, 16'h0100, 16'h0, 16'h0, 5'h0F, 1'b1);
      check("sw_result", result, 16'h010F);
      check_strb("sw_strobes", 3'b100);

      // CMP equal then JE (taken) and JNE (not taken).
      issue(6'h0C, 16'h0005, 16'h0005, 16'h0, 5'h0, 1'b0);
      check("cmp_eq_result", result, 16'h0005);
      check_strb("cmp_eq_strobes", 3'b010);
      issue(6'h0E, 16'h0, 16'h0, 16'h0040, 5'h0, 1'b0);
      check("je_result", result, 16'h0040);
      check_strb("je_strobes", 3'b011);
      issue(6'h0F, 16'h0, 16'h0, 16'h0080, 5'h0, 1'b0);
      check("jne_result", result, 16'h0080);
      check_strb("jne_strobes", 3'b010);

      // CMP -2 vs 1: N=1, V=0 -> JL taken, JG not.
      issue(6'h0C, 16'h0001, 16'hFFFE, 16'h0, 5'h0, 1'b0);
      check("cmp_lt_result", result, 16'hFFFE);
      issue(6'h11, 16'h0, 16'h0, 16'h0100, 5'h0, 1'b0);
      check("jl_result", result, 16'h0100);
      check_strb("jl_strobes", 3'b011);
      issue(6'h10, 16'h0, 16'h0, 16'h0200, 5'h0, 1'b0);
      check("jg_result", result, 16'h0200);
      check_strb("jg_strobes", 3'b010);
      issue(6'h0D, 16'h0, 16'h0, 16'h0300, 5'h0, 1'b0);
      check_strb("jmp_strobes", 3'b011);

      // Back-to-back: SUB then XOR, each gets its own pulse.
      @(negedge clk);
      drive(6'h02, 16'h0005, 16'h0003, 16'h0, 5'h0, 1'b0);
      @(posedge clk);
      #1;
      check("b2b_sub_result", result, 16'hFFFE);
      check_strb("b2b_sub_strobes", 3'b010);
      drive(6'h09, 16'hFF00, 16'hF0F0, 16'h0, 5'h0, 1'b0);
      @(posedge clk);
      #1;
      ce = 1'b0;
      check("b2b_xor_result", result, 16'h0FF0);
      check_strb("b2b_xor_strobes", 3'b010);

      // MOVI then undefined opcodes clear result but keep flags.
      issue(6'h05, 16'h0, 16'h0, 16'h1234, 5'h0, 1'b0);
      check("movi_result", result, 16'h1234);
      issue(6'h00, 16'h1111, 16'h2222, 16'h3333, 5'h0, 1'b0);
      check("undef00_result", result, 16'h0000);
      check_strb("undef00_strobes", 3'b010);
      issue(6'h15, 16'h1111, 16'h1111, 16'h3333, 5'h0, 1'b0);
      check("undef15_result", result, 16'h0000);
      issue(6'h11, 16'h0, 16'h0, 16'h0044, 5'h0, 1'b0);
      check_strb("flags_kept_jl", 3'b011);

      // Shift: only implemented with PRCO_ALU_SHIFT_EN.
      issue(6'h0A, 16'h0004, 16'h0001, 16'h0, 5'h0, 1'b0);
`ifdef PRCO_ALU_SHIFT_EN
      check("lsl_result", result, 16'h0010);
`else
      check("lsl_result", result, 16'h0000);
`endif
      check_strb("lsl_strobes", 3'b010);
      issue(6'h0B, 16'h0004, 16'h8000, 16'h0, 5'h0, 1'b0);
`ifdef PRCO_ALU_SHIFT_EN
      check("lsr_result", result, 16'h0800);
`else
      check("lsr_result", result, 16'h0000);
`endif

      // Other ops.
      issue(6'h14, 16'h0, 16'h0041, 16'h0, 5'h0, 1'b0);
      check("uart_result", result, 16'h0041);
      issue(6'h04, 16'h0, 16'h0010, 16'h0011, 5'h0, 1'b0);
      check("subi_result", result, 16'hFFFF);
      issue(6'h3F, 16'h1, 16'h1, 16'h1, 5'h0, 1'b0);
      check("halt_result", result, 16'h0000);

      // Async reset mid-pulse clears strobes immediately.
      issue(6'h11, 16'h0, 16'h0, 16'h0055, 5'h0, 1'b0);
      check_strb("pre_reset_jl", 3'b011);
      #1;
      rst = 1'b1;
      #1;
      check_strb("async_reset_strobes", 3'b000);
      check("async_reset_result", result, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      // Flags cleared by reset: JL now not taken.
      issue(6'h11, 16'h0, 16'h0, 16'h0066, 5'h0, 1'b0);
      check_strb("post_reset_jl", 3'b010);
      check("post_reset_jl_result", result, 16'h0066);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
